hilo_div_ctrl: RTL and testbench

HILO_DIV_CTRL -- requirements
Module: hilo_div_ctrl

---
 rtl/hilo_div_ctrl.sv | 128 ++++++++++++
 tb/tb_hilo_div_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU unit for the HI/LO pair: restoring divider, one quotient bit per cycle,
// with pipeline stall, flush squash and divide-by-zero bypass.
module hilo_div_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        hl_write_enable,
    output logic [63:0] hl_data,
    output logic        div_by_zero,
    output logic [1:0]  state_dbg
);

    // Handshake: start is accepted only in IDLE with flush low; the result is valid
    // exactly in the single cycle hl_write_enable is high, with no back-pressure.

    localparam int CW = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [31:0]    quo;
    logic [31:0]    rem;
    logic [31:0]    dsr;
    logic           neg_q, neg_r, dbz;

    logic           accept;
    logic           last;
    logic [31:0]    a_mag, b_mag;
    logic [32:0]    shifted;
    logic           fits;
    logic [31:0]    rem_step, quo_step;
    logic [31:0]    q_final, r_final;

    assign accept = (state == IDLE) && start && !flush;
    assign last   = (cnt == CW'(1));
    assign a_mag  = (is_signed && dividend[31]) ? -dividend : dividend;
    assign b_mag  = (is_signed && divisor[31])  ? -divisor  : divisor;

    // 33-bit partial remainder: previous remainder shifted left with the next dividend bit.
    assign shifted  = {rem, quo[31]};
    assign fits     = (shifted >= {1'b0, dsr});
    assign rem_step = fits ? 32'(shifted - {1'b0, dsr}) : shifted[31:0];
    assign quo_step = {quo[30:0], fits};
    assign q_final  = neg_q ? -quo_step : quo_step;
    assign r_final  = neg_r ? -rem_step : rem_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (divisor == 32'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall           = rst && (accept || (state == CALC));
        busy            = (state != IDLE);
        hl_write_enable = (state == DONE) && !flush;
        div_by_zero     = hl_write_enable && dbz;
        state_dbg       = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dsr     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dbz     <= 1'b0;
            hl_data <= '0;
        end else if (accept) begin
            cnt   <= CW'(DIV_CYCLES);
            quo   <= a_mag;
            rem   <= '0;
            dsr   <= b_mag;
            neg_q <= is_signed && (dividend[31] ^ divisor[31]);
            neg_r <= is_signed && dividend[31];
            dbz   <= (divisor == 32'd0);
            if (divisor == 32'd0) begin
                hl_data <= {dividend, 32'hFFFF_FFFF};
            end
        end else if ((state == CALC) && !flush) begin
            cnt <= cnt - CW'(1);
            quo <= quo_step;
            rem <= rem_step;
            // Result lands as DONE is entered so it is stable for the whole write cycle.
            if (last) begin
                hl_data <= {r_final, q_final};
            end
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: results, latency, stall, divide-by-zero, flush and reset.
module tb_hilo_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        flush = 1'b0;
    logic        stall, busy, hl_write_enable, div_by_zero;
    logic [63:0] hl_data;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    int writes;
    int k;

    hilo_div_ctrl #(.DIV_CYCLES(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .is_signed       (is_signed),
        .dividend        (dividend),
        .divisor         (divisor),
        .flush           (flush),
        .stall           (stall),
        .busy            (busy),
        .hl_write_enable (hl_write_enable),
        .hl_data         (hl_data),
        .div_by_zero     (div_by_zero),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
    endtask

    // Full division from IDLE: checks issue-cycle stall, latency, stall length and result.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp_data);
        int lat;
        int stall_cnt;
        issue(sgn, a, b);
        settle;
        check({tag, "_issue_stall"}, 64'(stall), 64'd1);
        tick;
        start = 1'b0;
        settle;
        lat = 0;
        stall_cnt = 1;
        while (!hl_write_enable && lat < 100) begin
            if (stall) stall_cnt++;
            tick;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd32);
        check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'd33);
        check({tag, "_data"}, hl_data, exp_data);
        check({tag, "_dbz"}, 64'(div_by_zero), 64'd0);
        check({tag, "_done_stall"}, 64'(stall), 64'd0);
        check({tag, "_done_busy"}, 64'(busy), 64'd1);
        tick;
        check({tag, "_we_after"}, 64'(hl_write_enable), 64'd0);
        check({tag, "_idle"}, 64'(state_dbg), 64'd0);
        check({tag, "_held"}, hl_data, exp_data);
    endtask

    initial begin
        // Reset with start already high: nothing may leak out.
        issue(1'b0, 32'd100, 32'd7);
        tick;
        tick;
        check("rst_state", 64'(state_dbg), 64'd0);
        check("rst_hl_data", hl_data, 64'd0);
        check("rst_we", 64'(hl_write_enable), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);

        // Start in the release cycle is accepted.
        rst = 1'b1;
        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD);
        run_div("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000);
        run_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 64'h00000000_FFFFFFFF);

        // Divide by zero skips CALC.
        issue(1'b0, 32'd5, 32'd0);
        settle;
        check("dbz_issue_stall", 64'(stall), 64'd1);
        tick;
        start = 1'b0;
        settle;
        check("dbz_state", 64'(state_dbg), 64'd2);
        check("dbz_we", 64'(hl_write_enable), 64'd1);
        check("dbz_flag", 64'(div_by_zero), 64'd1);
        check("dbz_data", hl_data, 64'h00000005_FFFFFFFF);
        check("dbz_stall", 64'(stall), 64'd0);
        tick;
        check("dbz_we_after", 64'(hl_write_enable), 64'd0);
        check("dbz_flag_after", 64'(div_by_zero), 64'd0);

        // Flush beats start in IDLE.
        issue(1'b0, 32'd50, 32'd5);
        flush = 1'b1;
        settle;
        check("prio_stall", 64'(stall), 64'd0);
        tick;
        start = 1'b0;
        flush = 1'b0;
        settle;
        check("prio_state", 64'(state_dbg), 64'd0);
        check("prio_held", hl_data, 64'h00000005_FFFFFFFF);

        // Flush in DONE suppresses the write.
        issue(1'b1, 32'd9, 32'd0);
        tick;
        start = 1'b0;
        flush = 1'b1;
        settle;
        check("fdone_state", 64'(state_dbg), 64'd2);
        check("fdone_we", 64'(hl_write_enable), 64'd0);
        check("fdone_dbz", 64'(div_by_zero), 64'd0);
        tick;
        flush = 1'b0;
        settle;
        check("fdone_idle", 64'(state_dbg), 64'd0);
        check("fdone_data", hl_data, 64'h00000009_FFFFFFFF);

        // Flush in the 10th CALC cycle.
        issue(1'b0, 32'd1000, 32'd3);
        tick;
        start = 1'b0;
        repeat (9) tick;
        check("fcalc_state", 64'(state_dbg), 64'd1);
        flush = 1'b1;
        settle;
        check("fcalc_we", 64'(hl_write_enable), 64'd0);
        tick;
        flush = 1'b0;
        settle;
        check("fcalc_idle", 64'(state_dbg), 64'd0);
        check("fcalc_busy", 64'(busy), 64'd0);
        check("fcalc_stall", 64'(stall), 64'd0);
        check("fcalc_held", hl_data, 64'h00000009_FFFFFFFF);
        writes = 0;
        repeat (40) begin
            if (hl_write_enable) writes++;
            tick;
        end
        check("fcalc_no_write", 64'(writes), 64'd0);
        run_div("after_flush", 1'b0, 32'd9, 32'd4, 64'h00000001_00000002);

        // Start held high with changing operands: one write, original operands used.
        issue(1'b0, 32'd100, 32'd7);
        tick;
        dividend = 32'd1000;
        divisor  = 32'd3;
        k = 0;
        while (!hl_write_enable && k < 100) begin
            tick;
            k++;
        end
        check("held_latency", 64'(k), 64'd32);
        check("held_data", hl_data, 64'h00000002_0000000E);
        start = 1'b0;
        settle;
        writes = 0;
        repeat (40) begin
            if (hl_write_enable) writes++;
            tick;
        end
        check("held_writes", 64'(writes), 64'd1);

        // Asynchronous reset in the middle of CALC.
        issue(1'b1, 32'hFFFF_FFF9, 32'd2);
        tick;
        start = 1'b0;
        repeat (5) tick;
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        settle;
        check("mid_rst_state", 64'(state_dbg), 64'd0);
        check("mid_rst_data", hl_data, 64'd0);
        check("mid_rst_we", 64'(hl_write_enable), 64'd0);
        check("mid_rst_stall", 64'(stall), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_dbz", 64'(div_by_zero), 64'd0);
        tick;
        rst = 1'b1;
        writes = 0;
        repeat (40) begin
            if (hl_write_enable) writes++;
            tick;
        end
        check("mid_rst_no_write", 64'(writes), 64'd0);
        check("mid_rst_data_after", hl_data, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
